// File: rtl/cavlc_pkg.sv
// ---------------------------------------------------------------------------
// cavlc_pkg
// Shared definitions for the CAVLC zig-zag scanner slice:
//   COEFF_W_DEF  default coefficient width (two's complement)
//   BLK_COEFFS   coefficients per 4x4 residual block
//   ZZ           zig-zag position -> raster index lookup
//   zz_state_e   scanner FSM states
// ---------------------------------------------------------------------------
package cavlc_pkg;

  localparam int COEFF_W_DEF = 8;
  localparam int BLK_COEFFS  = 16;

  // ZZ[pos] is the raster index of the coefficient at zig-zag position pos.
  localparam logic [3:0] ZZ [BLK_COEFFS] = '{
    4'd0,  4'd1,  4'd4,  4'd8,
    4'd5,  4'd2,  4'd3,  4'd6,
    4'd9,  4'd12, 4'd13, 4'd10,
    4'd7,  4'd11, 4'd14, 4'd15
  };

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CLR  = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } zz_state_e;

endpackage

// File: rtl/cavlc_coeff_buf.sv
// ---------------------------------------------------------------------------
// cavlc_coeff_buf
// 16 x COEFF_W register file, one synchronous write port, one asynchronous
// read port. Contents are not reset; a block is always fully rewritten
// before it is read.
// Ports:
//   clk      clock
//   wr_en    write strobe
//   wr_addr  write address (raster index)
//   wr_data  write data
//   rd_addr  read address (raster index)
//   rd_data  read data, combinational from the stored word
// ---------------------------------------------------------------------------
module cavlc_coeff_buf
  import cavlc_pkg::*;
#(
  parameter int COEFF_W = COEFF_W_DEF
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [3:0]                wr_addr,
  input  logic signed [COEFF_W-1:0] wr_data,
  input  logic [3:0]                rd_addr,
  output logic signed [COEFF_W-1:0] rd_data
);

  logic signed [COEFF_W-1:0] mem [BLK_COEFFS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cavlc_zigzag_scanner.sv
// ---------------------------------------------------------------------------
// cavlc_zigzag_scanner
// Upstream feeder for the CAVLC total-zeros counter. Accepts a 4x4 residual
// block as 16 raster-order coefficients over valid/ready, buffers it, then
// replays it as a contiguous 16-cycle burst in reverse zig-zag order
// (position 15 down to 0). A one-cycle cnt_rst precedes the burst so the
// downstream counter restarts per block, and blk_done marks the cycle in
// which the downstream count is valid.
//
// Build option:
//   CAVLC_ZZ_PINGPONG_EN  two buffers; the loader fills one while the other
//                         is scanned, and DONE goes straight to CLR when the
//                         alternate buffer already holds a full block.
//                         Undefined: single buffer, loading stalls while the
//                         block is scanned.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   in_valid    upstream coefficient valid
//   in_ready    scanner can accept a coefficient
//   in_coeff    coefficient, raster order
//   out_valid   high during the 16-cycle scan burst
//   out_coeff   coefficient in reverse zig-zag order, 0 outside the burst
//   out_idx     zig-zag position of out_coeff, 0 outside the burst
//   out_last    high with out_idx = 0
//   cnt_rst     one-cycle clear to the downstream counters
//   blk_done    one-cycle pulse, downstream count valid
//
// All outputs decode registered state and counters only; nothing in in_*
// reaches out_* combinationally.
// ---------------------------------------------------------------------------
module cavlc_zigzag_scanner
  import cavlc_pkg::*;
#(
  parameter int COEFF_W = COEFF_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COEFF_W-1:0] in_coeff,
  output logic                      out_valid,
  output logic signed [COEFF_W-1:0] out_coeff,
  output logic [3:0]                out_idx,
  output logic                      out_last,
  output logic                      cnt_rst,
  output logic                      blk_done
);

  zz_state_e                 state;
  logic [3:0]                wr_ptr;
  logic [3:0]                rd_pos;
  logic                      wr_en;
  logic                      last_beat;
  logic                      scan_rdy;   // block for the next scan is complete
  logic                      alt_rdy;    // DONE may chain straight into CLR
  logic [3:0]                rd_addr;
  logic signed [COEFF_W-1:0] rd_data;

  assign wr_en     = in_valid && in_ready;
  assign last_beat = wr_en && (wr_ptr == 4'd15);
  assign rd_addr   = ZZ[rd_pos];

`ifdef CAVLC_ZZ_PINGPONG_EN
  // full[b]: buffer b holds a complete block not yet scanned.
  logic [1:0]                full;
  logic                      wr_sel;
  logic                      rd_sel;
  logic signed [COEFF_W-1:0] rd_data0;
  logic signed [COEFF_W-1:0] rd_data1;

  assign in_ready = ~full[wr_sel];

  // A block completing this cycle counts as ready so the CLR timing after
  // the 16th beat matches the single-buffer build.
  assign scan_rdy = full[rd_sel]  || (last_beat && (wr_sel == rd_sel));
  assign alt_rdy  = full[~rd_sel] || (last_beat && (wr_sel != rd_sel));

  cavlc_coeff_buf #(.COEFF_W(COEFF_W)) u_buf0 (
    .clk     (clk),
    .wr_en   (wr_en && (wr_sel == 1'b0)),
    .wr_addr (wr_ptr),
    .wr_data (in_coeff),
    .rd_addr (rd_addr),
    .rd_data (rd_data0)
  );

  cavlc_coeff_buf #(.COEFF_W(COEFF_W)) u_buf1 (
    .clk     (clk),
    .wr_en   (wr_en && (wr_sel == 1'b1)),
    .wr_addr (wr_ptr),
    .wr_data (in_coeff),
    .rd_addr (rd_addr),
    .rd_data (rd_data1)
  );

  assign rd_data = rd_sel ? rd_data1 : rd_data0;
`else
  assign in_ready = (state == LOAD);
  assign scan_rdy = last_beat;
  assign alt_rdy  = 1'b0;

  cavlc_coeff_buf #(.COEFF_W(COEFF_W)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (in_coeff),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );
`endif

  // Scanner FSM, write pointer and buffer bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOAD;
      wr_ptr <= 4'd0;
      rd_pos <= 4'd0;
`ifdef CAVLC_ZZ_PINGPONG_EN
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
`endif
    end else begin
      // 4-bit pointer wraps 15 -> 0 on the block-completing beat.
      if (wr_en) wr_ptr <= wr_ptr + 4'd1;

`ifdef CAVLC_ZZ_PINGPONG_EN
      // Fill and release never target the same buffer in one cycle: the
      // buffer being released is full, so the loader is not writing it.
      if (last_beat) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
      end
      if (state == DONE) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end
`endif

      case (state)
        LOAD: begin
          if (scan_rdy) state <= CLR;
        end
        CLR: begin
          state  <= SCAN;
          rd_pos <= 4'd15;
        end
        SCAN: begin
          if (rd_pos == 4'd0) state <= DONE;
          else                rd_pos <= rd_pos - 4'd1;
        end
        DONE: begin
          state <= alt_rdy ? CLR : LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign out_valid = (state == SCAN);
  assign out_idx   = out_valid ? rd_pos : 4'd0;
  assign out_coeff = out_valid ? rd_data : '0;
  assign out_last  = out_valid && (rd_pos == 4'd0);
  assign cnt_rst   = (state == CLR);
  assign blk_done  = (state == DONE);

endmodule

// File: tb/tb_cavlc_zigzag_scanner.sv
// ---------------------------------------------------------------------------
// tb_cavlc_zigzag_scanner
// Directed bench for cavlc_zigzag_scanner (default single-buffer build).
// Inputs change and outputs are sampled on the falling clock edge; the DUT
// acts on the rising edge. A small downstream total-zeros counter model is
// fed from the DUT outputs and its value is checked when blk_done fires.
// ---------------------------------------------------------------------------
module tb_cavlc_zigzag_scanner;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_coeff;
  logic              out_valid;
  logic signed [7:0] out_coeff;
  logic [3:0]        out_idx;
  logic              out_last;
  logic              cnt_rst;
  logic              blk_done;

  int n_chk  = 0;
  int n_fail = 0;

  // Downstream total-zeros counter model: cleared by cnt_rst, counts zeros
  // seen after the first nonzero coefficient (including idle zeros).
  int dn_cnt   = 0;
  int dn_cnt_q = 0;
  bit dn_seen  = 1'b0;

  logic signed [7:0] r_sparse [16];
  logic signed [7:0] e_sparse [16];
  logic signed [7:0] r_ramp   [16];
  logic signed [7:0] e_ramp   [16];
  logic signed [7:0] r_zero   [16];
  logic signed [7:0] r_neg    [16];
  logic signed [7:0] e_neg    [16];

  cavlc_zigzag_scanner #(.COEFF_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coeff  (in_coeff),
    .out_valid (out_valid),
    .out_coeff (out_coeff),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .cnt_rst   (cnt_rst),
    .blk_done  (blk_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and update the downstream model with
  // the outputs of the cycle just entered. dn_cnt_q is the counter value
  // held during that cycle.
  task automatic tick();
    @(negedge clk);
    dn_cnt_q = dn_cnt;
    if (cnt_rst) begin
      dn_cnt  = 0;
      dn_seen = 1'b0;
    end else if (out_coeff != 8'sd0) begin
      dn_seen = 1'b1;
    end else if (dn_seen) begin
      dn_cnt++;
    end
  endtask

  // Load a raster block (optionally idling one cycle between beats), then
  // check cnt_rst at T+1, the burst T+2..T+17, blk_done at T+18 and
  // in_ready at T+19.
  task automatic run_block(input string tag,
                           input logic signed [7:0] rast [16],
                           input logic signed [7:0] exp [16],
                           input bit gap,
                           input int exp_cnt);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_in_ready_load"}, int'(in_ready), 1);
      in_valid = 1'b1;
      in_coeff = rast[i];
      tick();
      if (gap && i != 15) begin
        in_valid = 1'b0;
        in_coeff = 8'sd0;
        tick();
      end
    end
    in_valid = 1'b0;
    in_coeff = 8'sd0;
    chk({tag, "_cnt_rst_T1"},   int'(cnt_rst),   1);
    chk({tag, "_in_ready_T1"},  int'(in_ready),  0);
    chk({tag, "_out_valid_T1"}, int'(out_valid), 0);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk({tag, "_out_valid"}, int'(out_valid), 1);
      chk({tag, "_out_idx"},   int'(out_idx),   15 - k);
      chk({tag, "_out_coeff"}, int'(out_coeff), int'(exp[k]));
      chk({tag, "_out_last"},  int'(out_last),  (k == 15) ? 1 : 0);
      chk({tag, "_in_ready"},  int'(in_ready),  0);
    end
    tick();
    chk({tag, "_blk_done"},     int'(blk_done),  1);
    chk({tag, "_valid_done"},   int'(out_valid), 0);
    chk({tag, "_coeff_done"},   int'(out_coeff), 0);
    chk({tag, "_total_zeros"},  dn_cnt_q,        exp_cnt);
    tick();
    chk({tag, "_blk_done_end"}, int'(blk_done),  0);
    chk({tag, "_in_ready_end"}, int'(in_ready),  1);
  endtask

  initial begin
    // Hand-computed vectors.
    for (int i = 0; i < 16; i++) begin
      r_sparse[i] = 8'sd0;
      e_sparse[i] = 8'sd0;
      r_zero[i]   = 8'sd0;
      r_ramp[i]   = 8'(i + 1);
      r_neg[i]    = -8'(i + 1);
    end
    r_sparse[0]  = 8'sd5;
    r_sparse[4]  = 8'sd1;
    e_sparse[13] = 8'sd1;  // out_idx 2
    e_sparse[15] = 8'sd5;  // out_idx 0
    e_ramp = '{8'sd16, 8'sd15, 8'sd12, 8'sd8, 8'sd11, 8'sd14, 8'sd13, 8'sd10,
               8'sd7,  8'sd4,  8'sd3,  8'sd6, 8'sd9,  8'sd5,  8'sd2,  8'sd1};
    for (int k = 0; k < 16; k++) e_neg[k] = -e_ramp[k];

    rst      = 1'b1;
    in_valid = 1'b0;
    in_coeff = 8'sd0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last",  int'(out_last),  0);
    chk("rst_cnt_rst",   int'(cnt_rst),   0);
    chk("rst_blk_done",  int'(blk_done),  0);
    chk("rst_out_coeff", int'(out_coeff), 0);
    chk("rst_out_idx",   int'(out_idx),   0);

    // Idle with no input: nothing starts, loader stays ready.
    for (int i = 0; i < 5; i++) tick();
    chk("idle_in_ready",  int'(in_ready),  1);
    chk("idle_out_valid", int'(out_valid), 0);

    run_block("sparse", r_sparse, e_sparse, 1'b0, 1);
    run_block("ramp",   r_ramp,   e_ramp,   1'b0, 0);
    run_block("zero",   r_zero,   r_zero,   1'b0, 0);
    run_block("gap",    r_neg,    e_neg,    1'b1, 0);

    // Reset in the middle of a scan.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_coeff = r_ramp[i];
      tick();
    end
    in_valid = 1'b0;
    in_coeff = 8'sd0;
    for (int k = 0; k < 9; k++) tick();
    chk("mid_out_idx",   int'(out_idx),   7);
    chk("mid_out_coeff", int'(out_coeff), int'(e_ramp[8]));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_in_ready",  int'(in_ready),  1);
    chk("mrst_blk_done",  int'(blk_done),  0);
    chk("mrst_out_idx",   int'(out_idx),   0);
    chk("mrst_out_coeff", int'(out_coeff), 0);
    begin
      int bd = 0;
      int ov = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (blk_done)  bd++;
        if (out_valid) ov++;
      end
      chk("mrst_no_blk_done",  bd, 0);
      chk("mrst_no_out_valid", ov, 0);
    end
    run_block("fresh", r_sparse, e_sparse, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
